// File: rtl/trig_record_readout.sv
// Trigger record FIFO and byte-serial packet readout for the 8-bit trigger former.
// Define TRIG_RECORD_SEQNUM_EN to tag every record with an 8-bit sequence number (10-byte packets).
module trig_record_readout #(
  parameter int unsigned DEPTH  = 16,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                       clk_adc,
  input  logic                       nrst,
  input  logic                       rec_valid,
  input  logic [7:0]                 rec_mask,
  input  logic [55:0]                rec_time,
  input  logic                       flush,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                overflow_count,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef TRIG_RECORD_SEQNUM_EN
  localparam int unsigned RW = 72;
`else
  localparam int unsigned RW = 64;
`endif
  localparam int unsigned NB = RW / 8 + 1;
  localparam int unsigned IW = $clog2(NB);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [RW-1:0]   sreg;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   wr_rec;
  logic            full, wr_en, accept, last, pop;

`ifdef TRIG_RECORD_SEQNUM_EN
  logic [7:0] seq;

  // Sequence advances on every offered record, so gaps in the stream reveal drops.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst)          seq <= '0;
    else if (rec_valid) seq <= seq + 8'(1);
  end

  assign wr_rec = {seq, rec_mask, rec_time};
`else
  assign wr_rec = {rec_mask, rec_time};
`endif

  assign full   = (fifo_count == CW'(DEPTH));
  assign wr_en  = rec_valid && !flush && !full;
  assign accept = out_valid && out_ready;
  assign last   = (idx == IW'(NB - 1));
  assign pop    = !flush && (fifo_count != '0) &&
                  ((state == IDLE) || (state == SEND && accept && last));

  always_ff @(posedge clk_adc) begin
    if (wr_en) mem[wr_ptr] <= wr_rec;
  end

  // Pointers, occupancy and drop counter; flush wins over a same-edge write.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      overflow_count <= '0;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      overflow_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (rec_valid && full && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'(1);
    end
  end

  // Packet FSM: out_data holds the current byte, sreg the bytes still to follow.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sreg      <= '0;
      idx       <= '0;
    end else if (pop) begin
      state     <= SEND;
      out_data  <= HEADER;
      sreg      <= mem[rd_ptr];
      idx       <= '0;
      out_valid <= 1'b1;
      busy      <= 1'b1;
    end else if (state == SEND && accept) begin
      if (last) begin
        state     <= IDLE;
        out_data  <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        out_data <= sreg[RW-1 -: 8];
        sreg     <= {sreg[RW-9:0], 8'h00};
        idx      <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_trig_record_readout.sv
// Randomised bench for trig_record_readout (default build, 9-byte packets) against a queue-level model.
module tb_trig_record_readout;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NB    = 9;

  logic        clk_adc = 1'b0;
  logic        nrst;
  logic        rec_valid;
  logic [7:0]  rec_mask;
  logic [55:0] rec_time;
  logic        flush;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_q[$];
  logic [7:0]  m_pkt[$];
  int          m_ovf;
  logic [7:0]  got[$];
  logic [7:0]  exp[$];
  logic [63:0] recs[$];

  always #4 clk_adc = ~clk_adc;

  trig_record_readout #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .clk_adc(clk_adc), .nrst(nrst), .rec_valid(rec_valid), .rec_mask(rec_mask),
    .rec_time(rec_time), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow_count(overflow_count),
    .busy(busy)
  );

  function automatic void add_packet(input logic [63:0] r, inout logic [7:0] q[$]);
    q.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) q.push_back(r[i*8 +: 8]);
  endfunction

  // One clock edge of the spec: at most one pop, fullness judged on the old count.
  function automatic void model_edge();
    int cnt = m_q.size();
    bit sending = (m_pkt.size() != 0);
    bit acc = sending && out_ready;
    bit lst = (m_pkt.size() == 1);
    bit pop = !flush && cnt > 0 && (!sending || (acc && lst));
    if (acc) void'(m_pkt.pop_front());
    if (pop) add_packet(m_q.pop_front(), m_pkt);
    if (flush) begin
      m_q.delete();
      m_ovf = 0;
    end else if (rec_valid) begin
      if (cnt == DEPTH) begin
        if (m_ovf < 65535) m_ovf++;
      end else m_q.push_back({rec_mask, rec_time});
    end
  endfunction

  task automatic tick();
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk_adc);
    model_edge();
    #1;
  endtask

  task automatic rand_rec(input bit v);
    rec_valid = v;
    rec_mask  = 8'($urandom);
    rec_time  = 56'({$urandom, $urandom});
    if (v) recs.push_back({rec_mask, rec_time});
  endtask

  task automatic test_reset();
    nrst = 1'b0; rec_valid = 0; rec_mask = 0; rec_time = 0; flush = 0; out_ready = 0;
    m_q.delete(); m_pkt.delete(); m_ovf = 0;
    repeat (2) @(posedge clk_adc);
    #1;
    checks++;
    if (out_data !== 8'h00 || out_valid !== 1'b0 || fifo_count !== 5'd0 ||
        overflow_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h valid=%b cnt=%0d ovf=%0d busy=%b, required all zero",
               out_data, out_valid, fifo_count, overflow_count, busy);
    end
    nrst = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] want [NB] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    got.delete();
    out_ready = 1; rec_valid = 1; rec_mask = 8'h05; rec_time = 56'h00_0000_1234_5678;
    tick();
    rec_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL single_edge1: valid=%b cnt=%0d, required valid=0 cnt=1", out_valid, fifo_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || busy !== 1'b1 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL single_latency: valid=%b data=%h busy=%b cnt=%0d, required 1 a5 1 0",
               out_valid, out_data, busy, fifo_count);
    end
    repeat (NB) tick();
    checks++;
    if (got.size() != NB || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: bytes=%0d valid=%b busy=%b, required 9 0 0", got.size(), out_valid, busy);
    end
    for (int i = 0; i < NB && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got %h required %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, lastv = -1, nvalid = 0;
    got.delete(); exp.delete(); recs.delete();
    out_ready = 1;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) rand_rec(1); else rec_valid = 0;
      tick();
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = c;
        lastv = c;
      end
      checks++;
      if (out_valid !== (m_pkt.size() != 0) || busy !== (m_pkt.size() != 0) ||
          fifo_count !== 5'(m_q.size()) || overflow_count !== 16'(m_ovf) ||
          (m_pkt.size() != 0 && out_data !== m_pkt[0])) begin
        errors++;
        $display("FAIL b2b_cycle%0d: valid=%b data=%h cnt=%0d, required valid=%b cnt=%0d",
                 c, out_valid, out_data, fifo_count, m_pkt.size() != 0, m_q.size());
      end
    end
    checks++;
    if (nvalid != 27 || lastv - first + 1 != 27) begin
      errors++;
      $display("FAIL b2b_gapless: valid cycles=%0d span=%0d, required 27 27", nvalid, lastv - first + 1);
    end
    foreach (recs[i]) add_packet(recs[i], exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL b2b_order: got %0d bytes, required %0d bytes in write order", got.size(), exp.size());
    end
  endtask

  task automatic test_stall_toggle();
    got.delete(); exp.delete(); recs.delete();
    for (int c = 0; c < 60; c++) begin
      if (c < 2) rand_rec(1); else rec_valid = 0;
      out_ready = c[0];
      tick();
      checks++;
      if (out_valid !== (m_pkt.size() != 0) || busy !== (m_pkt.size() != 0) ||
          fifo_count !== 5'(m_q.size()) || (m_pkt.size() != 0 && out_data !== m_pkt[0])) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h cnt=%0d, required valid=%b",
                 c, out_valid, out_data, fifo_count, m_pkt.size() != 0);
      end
    end
    foreach (recs[i]) add_packet(recs[i], exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL stall_stream: got %0d bytes, required %0d bytes, no duplicates or skips",
               got.size(), exp.size());
    end
  endtask

  task automatic test_overflow();
    int c = 0;
    got.delete(); exp.delete(); recs.delete();
    out_ready = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      rand_rec(1);
      tick();
    end
    rec_valid = 0;
    checks++;
    if (fifo_count !== 5'd16 || overflow_count !== 16'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: cnt=%0d ovf=%0d valid=%b, required 16 2 1", fifo_count, overflow_count, out_valid);
    end
    out_ready = 1;
    while ((out_valid || fifo_count != 0) && c < 400) begin
      tick();
      c++;
      checks++;
      if (out_valid !== (m_pkt.size() != 0) || fifo_count !== 5'(m_q.size()) ||
          overflow_count !== 16'(m_ovf) || (m_pkt.size() != 0 && out_data !== m_pkt[0])) begin
        errors++;
        $display("FAIL ovf_drain%0d: valid=%b data=%h cnt=%0d ovf=%0d", c, out_valid, out_data,
                 fifo_count, overflow_count);
      end
    end
    checks++;
    if (c >= 400) begin
      errors++;
      $display("FAIL ovf_timeout: still busy after %0d cycles, required drain", c);
    end
    for (int i = 0; i <= DEPTH; i++) add_packet(recs[i], exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL ovf_order: got %0d bytes, required %0d (records 0..16)", got.size(), exp.size());
    end
  endtask

  task automatic test_flush();
    int c = 0;
    got.delete(); exp.delete(); recs.delete();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rand_rec(1);
      tick();
    end
    rec_valid = 0;
    checks++;
    if (fifo_count !== 5'd4) begin
      errors++;
      $display("FAIL flush_pre: cnt=%0d required 4", fifo_count);
    end
    out_ready = 1;
    repeat (3) tick();
    flush = 1; rand_rec(1); void'(recs.pop_back());
    tick();
    flush = 0; rec_valid = 0;
    checks++;
    if (fifo_count !== 5'd0 || overflow_count !== 16'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: cnt=%0d ovf=%0d valid=%b, required 0 0 1", fifo_count, overflow_count, out_valid);
    end
    while (out_valid && c < 40) begin
      tick();
      c++;
    end
    repeat (3) tick();
    add_packet(recs[0], exp);
    checks++;
    if (got != exp || out_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL flush_finish: got %0d bytes valid=%b cnt=%0d, required 9 bytes of record 0 then idle",
               got.size(), out_valid, fifo_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rand_rec(($urandom % 4) == 0);
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 250) == 0;
      tick();
      checks++;
      if (out_valid !== (m_pkt.size() != 0) || busy !== (m_pkt.size() != 0) ||
          fifo_count !== 5'(m_q.size()) || overflow_count !== 16'(m_ovf) ||
          (m_pkt.size() != 0 && out_data !== m_pkt[0])) begin
        errors++;
        $display("FAIL rand_cycle%0d: valid=%b data=%h cnt=%0d ovf=%0d, required valid=%b cnt=%0d ovf=%0d",
                 c, out_valid, out_data, fifo_count, overflow_count, m_pkt.size() != 0,
                 m_q.size(), m_ovf);
      end
    end
    flush = 0; rec_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_toggle();
    test_overflow();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
